four_to_two_encoder: RTL and testbench

Registered 4-to-2 encoder: the inverse of the team's two_to_four decoder. It samples four request lines (Y3..Y0) and returns the 2-bit index (A1,A0) of the selected line. The result is held under a valid/ready handshake, and a multi-hot flag is raised when more than one line is active. Sits in front of two_to_four in the loopback path, so the decoder output can be re-encoded and checked.

---
 rtl/enc_pkg.sv | 15 +
 rtl/four_to_two_encoder_rr_select4.sv | 39 +++
 rtl/four_to_two_encoder.sv | 138 +++++++++++++
 tb/tb_four_to_two_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the four_to_two encoder and the two_to_four decoder.
//   N_REQ  : number of request lines (4)
//   CODE_W : width of the encoded index (2)
//   state_t: encoder handshake state (IDLE = no result held, HOLD = result held)
package enc_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/four_to_two_encoder_rr_select4.sv
// rr_select4: combinational 4-way selector.
//   req   [3:0] : request vector
//   start [1:0] : first position searched; the search continues upward mod 4
//   idx   [1:0] : first set position found (0 when req is empty)
//   any         : at least one request set
//   multi       : two or more requests set
module rr_select4
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              multi
);

  logic              found;
  logic [CODE_W-1:0] pos;
  logic [2:0]        cnt;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    cnt   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // pos wraps naturally because it is exactly CODE_W bits wide
      pos = start + CODE_W'(k);
      if (!found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
      cnt = cnt + 3'(req[k]);
    end
    any   = found;
    multi = (cnt >= 3'd2);
  end

endmodule

// File: rtl/four_to_two_encoder.sv
// four_to_two_encoder: registered 4-to-2 encoder with valid/ready hand-off.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : sampling enable
//   Y3..Y0          : request lines
//   ready           : consumer accepts the held result when valid=1
//   A1, A0          : encoded index of the selected request (registered)
//   valid           : {A1,A0,multi} hold an unaccepted result
//   multi           : more than one request was active at capture
// RR_MODE=0 selects the highest set line; RR_MODE=1 searches upward from a
// round-robin pointer that advances past each accepted index.
module four_to_two_encoder #(
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned N_REQ   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic Y3,
  input  logic Y2,
  input  logic Y1,
  input  logic Y0,
  input  logic ready,
  output logic A1,
  output logic A0,
  output logic valid,
  output logic multi
);
  import enc_pkg::CODE_W;
  import enc_pkg::state_t;
  import enc_pkg::IDLE;
  import enc_pkg::HOLD;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  sel_req;
  logic [CODE_W-1:0] sel_start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic              sel_multi;
  logic [CODE_W-1:0] enc_code;

  state_t            state, state_d;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic              valid_q;
  logic              multi_q;
  logic              accept;
  logic              capture;
  logic              load;

  assign req = {Y3, Y2, Y1, Y0};

  // A transfer completes whenever a held result meets ready.
  assign accept = (state == HOLD) && ready;

  // The pointer update is visible to the selector in the same cycle so a
  // back-to-back capture already searches from the advanced position.
  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE == 0) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = code_q + CODE_W'(1);
    end
  end

  // Fixed priority reuses the round-robin search: mirroring the request
  // vector and starting at 0 finds the highest set line; the mirrored index
  // is turned back into a real index by inversion (3-i on two bits).
  always_comb begin
    sel_req   = req;
    sel_start = ptr_d;
    if (RR_MODE == 0) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sel_req[k] = req[N_REQ-1-k];
      end
      sel_start = '0;
    end
  end

  rr_select4 u_sel (
    .req   (sel_req),
    .start (sel_start),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  assign enc_code = (RR_MODE == 0) ? ~sel_idx : sel_idx;

  assign capture = enable && sel_any && ((state == IDLE) || ready);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (ready) begin
          if (capture) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state   <= state_d;
      valid_q <= (state_d == HOLD);
      ptr_q   <= ptr_d;
      if (load) begin
        code_q  <= enc_code;
        multi_q <= sel_multi;
      end
    end
  end

  assign A1    = code_q[1];
  assign A0    = code_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_four_to_two_encoder.sv
module tb_four_to_two_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] req_v = 4'b0000;

  logic fa1, fa0, fv, fm;
  logic ra1, ra0, rv, rm;

  int total  = 0;
  int passed = 0;

  // reference state, index 0 = fixed priority, index 1 = round robin
  int m_valid [2];
  int m_code  [2];
  int m_multi [2];
  int m_ptr   [2];

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       rdy;
    logic       exp_valid;
    int         exp_code;
    logic       exp_multi;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  four_to_two_encoder #(.RR_MODE(0), .N_REQ(4)) u_fix (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .Y3(req_v[3]), .Y2(req_v[2]), .Y1(req_v[1]), .Y0(req_v[0]),
    .ready(ready), .A1(fa1), .A0(fa0), .valid(fv), .multi(fm)
  );

  four_to_two_encoder #(.RR_MODE(1), .N_REQ(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .Y3(req_v[3]), .Y2(req_v[2]), .Y1(req_v[1]), .Y0(req_v[0]),
    .ready(ready), .A1(ra1), .A0(ra0), .valid(rv), .multi(rm)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  function automatic int pick(input logic [3:0] r, input int mode, input int ptr);
    if (mode == 0) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_code[m] = 0; m_multi[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit acc, cap;
      acc = (m_valid[m] != 0) && ready;
      if (acc && m == 1) m_ptr[m] = (m_code[m] + 1) % 4;
      cap = enable && (req_v != 0) && ((m_valid[m] == 0) || ready);
      if (cap) begin
        m_code[m]  = pick(req_v, m, m_ptr[m]);
        m_multi[m] = ($countones(req_v) >= 2) ? 1 : 0;
        m_valid[m] = 1;
      end else if (acc) begin
        m_valid[m] = 0;
      end
    end
  endtask

  // inputs are already set; advance one edge and settle
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    tbl[1]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    tbl[2]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2, 1'b0};
    tbl[3]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 3, 1'b0};
    tbl[4]  = '{4'b1011, 1'b1, 1'b1, 1'b1, 3, 1'b1};
    tbl[5]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    tbl[6]  = '{4'b1000, 1'b1, 1'b0, 1'b1, 1, 1'b0};
    tbl[7]  = '{4'b1000, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[9]  = '{4'b1000, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[14] = '{4'b0100, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    // reset state
    do_reset();
    chk("reset_code", {fa1, fa0}, 0);
    chk("reset_valid", fv, 0);
    chk("reset_multi", fm, 0);
    chk("reset_rr_valid", rv, 0);

    // fixed priority, backpressure, idle gating
    for (int i = 0; i < 15; i++) begin
      req_v = tbl[i].req; enable = tbl[i].en; ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), fv, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_code", i), {fa1, fa0}, tbl[i].exp_code);
        chk($sformatf("tbl%0d_multi", i), fm, tbl[i].exp_multi);
      end
    end

    // round robin with all lines requesting, including wrap 3 -> 0
    do_reset();
    req_v = 4'b1111; enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d_code", i), {ra1, ra0}, i % 4);
      chk($sformatf("rr%0d_valid", i), rv, 1);
      chk($sformatf("rr%0d_multi", i), rm, 1);
    end

    // asynchronous reset while a result is held
    do_reset();
    req_v = 4'b0100; enable = 1'b1; ready = 1'b0;
    tick();
    chk("prerst_code", {fa1, fa0}, 2);
    chk("prerst_valid", fv, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_code", {fa1, fa0}, 0);
    chk("midrst_valid", fv, 0);
    chk("midrst_multi", fm, 0);
    chk("midrst_rr_valid", rv, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // loopback through a two_to_four style decode
    do_reset();
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] onehot, dec;
      onehot = 4'b0001 << i;
      req_v = onehot;
      tick();
      dec = 4'b0001 << {fa1, fa0};
      chk($sformatf("loop%0d_dec", i), dec, onehot);
      chk($sformatf("loop%0d_multi", i), fm, 0);
    end

    // randomized against reference model, both modes
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_v  = 4'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      ready  = 1'($urandom);
      tick();
      chk("rnd_fix_valid", fv, m_valid[0]);
      chk("rnd_rr_valid", rv, m_valid[1]);
      if (m_valid[0] != 0) begin
        chk("rnd_fix_code", {fa1, fa0}, m_code[0]);
        chk("rnd_fix_multi", fm, m_multi[0]);
      end
      if (m_valid[1] != 0) begin
        chk("rnd_rr_code", {ra1, ra0}, m_code[1]);
        chk("rnd_rr_multi", rm, m_multi[1]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
